// File: rtl/token_packer.sv
// token_packer: packs an LSB-first serial token stream into W-bit words and queues them in a DEPTH-entry valid/ready FIFO.
// Define TOKEN_PACKER_ONES_EN to store each word's popcount and present it on out_ones.
module token_packer #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_bit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
`ifdef TOKEN_PACKER_ONES_EN
    output logic [$clog2(W+1)-1:0]       out_ones,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);
    localparam int CW = $clog2(W);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    logic [CW-1:0] cnt;
    logic [W-1:0]  sr, word;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          done, full, pop, push;
    // word is the shift register with the current bit merged in, so a completing word is pushed on its last edge
    always_comb begin
        word = sr;
        word[cnt] = in_bit;
    end
    assign done      = en && cnt == CW'(W - 1);
    assign full      = level == LW'(DEPTH);
    assign out_valid = level != '0;
    assign pop       = out_valid && out_ready;
    assign push      = done && (!full || pop);
    assign out_data  = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sr       <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (en) begin
                sr  <= word;
                cnt <= done ? '0 : cnt + CW'(1);
            end
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push != pop) level <= push ? level + LW'(1) : level - LW'(1);
            if (done && full && !pop) overflow <= 1'b1;
        end
    end
`ifdef TOKEN_PACKER_ONES_EN
    localparam int OW = $clog2(W + 1);
    logic [OW-1:0] ones;
    logic [OW-1:0] ones_mem [DEPTH];
    always_comb begin
        ones = '0;
        for (int i = 0; i < W; i++) ones = ones + OW'(word[i]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ones_mem[i] <= '0;
        end else if (push) begin
            ones_mem[wr_ptr] <= ones;
        end
    end
    assign out_ones = ones_mem[rd_ptr];
`endif
endmodule
